// File: rtl/reg_wb_queue_pkg.sv
// Shared processor types for the register writeback path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package reg_wb_queue_pkg;

  localparam int WB_DEPTH = 4;
  localparam int WB_AW    = 6;
  localparam int WB_DW    = 32;

  // One pending register-file write.
  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_wb_queue_match.sv
// Youngest-match search of a query address over the writeback queue and the write-port register.
// Latency: combinational.
// Backpressure: none; pure lookup.
module wb_match
  import reg_wb_queue_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic [AW-1:0]              query_addr,
  input  wb_entry_t                  entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [$clog2(DEPTH):0]     count,
  input  wb_entry_t                  out_entry,
  input  logic                       out_valid,
  output logic                       pending,
  output logic [DW-1:0]              fwd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last hit (nearest the tail) wins; the write-port register is oldest.
  always_comb begin
    pending  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    if (query_addr != '0) begin
      if (out_valid && (out_entry.addr == query_addr)) begin
        pending  = 1'b1;
        fwd_data = out_entry.data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PW'(i);
        if ((CW'(i) < count) && (entries[idx].addr == query_addr)) begin
          pending  = 1'b1;
          fwd_data = entries[idx].data;
        end
      end
    end
  end

endmodule

// File: rtl/reg_wb_queue.sv
// In-order register writeback queue merging load and ALU results onto one register-file write port.
// Latency: 1 cycle from enqueue into an empty queue to REG_write_1; one write drained per cycle.
// Backpressure: WB_ready drops when fewer than 2 entries are free; requests arriving then are dropped and flagged in sticky WB_overflow.
module reg_wb_queue
  import reg_wb_queue_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       WB_mem_valid,
  input  logic [AW-1:0]              WB_mem_addr,
  input  logic [DW-1:0]              WB_mem_data,
  input  logic                       WB_alu_valid,
  input  logic [AW-1:0]              WB_alu_addr,
  input  logic [DW-1:0]              WB_alu_data,
  output logic                       WB_ready,
  output logic                       REG_write_1,
  output logic [AW-1:0]              REG_address_wr,
  output logic [DW-1:0]              REG_data_wb_in1,
  input  logic [AW-1:0]              WB_query_addr1,
  input  logic [AW-1:0]              WB_query_addr2,
  output logic                       WB_pending1,
  output logic                       WB_pending2,
  output logic [DW-1:0]              WB_fwd_data1,
  output logic [DW-1:0]              WB_fwd_data2,
  output logic [$clog2(DEPTH):0]     WB_count,
  output logic                       WB_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t     q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          mem_req;
  logic          alu_req;
  logic          mem_acc;
  logic          alu_acc;
  logic          pop;
  logic [1:0]    n_enq;
  logic [PW-1:0] alu_slot;
  wb_entry_t     out_entry;

  // Register 0 is hardwired, so writes to it are not requests at all.
  assign mem_req  = WB_mem_valid && (WB_mem_addr != '0);
  assign alu_req  = WB_alu_valid && (WB_alu_addr != '0);

  // Ready depends on count alone; two free slots means both sources can always land together.
  assign WB_ready = (CW'(DEPTH) - count) >= CW'(2);
  assign mem_acc  = mem_req && WB_ready;
  assign alu_acc  = alu_req && WB_ready;
  assign pop      = (count != '0);
  assign n_enq    = {1'b0, mem_acc} + {1'b0, alu_acc};

  // Mem result is older, so it takes the tail slot and the ALU result goes behind it.
  assign alu_slot = tail + PW'(mem_acc);

  assign WB_count  = count;
  assign out_entry = '{addr: REG_address_wr, data: REG_data_wb_in1};

  // Entry storage; contents are don't-care until the pointers cover them, so no reset.
  always_ff @(posedge clk) begin
    if (mem_acc) q[tail]     <= '{addr: WB_mem_addr, data: WB_mem_data};
    if (alu_acc) q[alu_slot] <= '{addr: WB_alu_addr, data: WB_alu_data};
  end

  // Pointer and occupancy update: wrap modulo DEPTH, count moves by enqueued minus popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(n_enq);
      count <= count + CW'(n_enq) - CW'(pop);
    end
  end

  // Drain the head into the registered write port every cycle the queue holds something.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      REG_write_1     <= 1'b0;
      REG_address_wr  <= '0;
      REG_data_wb_in1 <= '0;
    end else begin
      REG_write_1 <= pop;
      if (pop) begin
        REG_address_wr  <= q[head].addr;
        REG_data_wb_in1 <= q[head].data;
      end
    end
  end

  // Sticky flag for any real request lost because the queue lacked room.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WB_overflow <= 1'b0;
    end else if ((mem_req || alu_req) && !WB_ready) begin
      WB_overflow <= 1'b1;
    end
  end

  wb_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match1 (
    .query_addr (WB_query_addr1),
    .entries    (q),
    .head       (head),
    .count      (count),
    .out_entry  (out_entry),
    .out_valid  (REG_write_1),
    .pending    (WB_pending1),
    .fwd_data   (WB_fwd_data1)
  );

  wb_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match2 (
    .query_addr (WB_query_addr2),
    .entries    (q),
    .head       (head),
    .count      (count),
    .out_entry  (out_entry),
    .out_valid  (REG_write_1),
    .pending    (WB_pending2),
    .fwd_data   (WB_fwd_data2)
  );

endmodule

// File: tb/tb_reg_wb_queue.sv
// Self-checking bench for reg_wb_queue against a queue-based behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_reg_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_mem_valid;
  logic [5:0]  WB_mem_addr;
  logic [31:0] WB_mem_data;
  logic        WB_alu_valid;
  logic [5:0]  WB_alu_addr;
  logic [31:0] WB_alu_data;
  logic        WB_ready;
  logic        REG_write_1;
  logic [5:0]  REG_address_wr;
  logic [31:0] REG_data_wb_in1;
  logic [5:0]  WB_query_addr1;
  logic [5:0]  WB_query_addr2;
  logic        WB_pending1;
  logic        WB_pending2;
  logic [31:0] WB_fwd_data1;
  logic [31:0] WB_fwd_data2;
  logic [2:0]  WB_count;
  logic        WB_overflow;

  reg_wb_queue dut (
    .clk             (clk),
    .rst             (rst),
    .WB_mem_valid    (WB_mem_valid),
    .WB_mem_addr     (WB_mem_addr),
    .WB_mem_data     (WB_mem_data),
    .WB_alu_valid    (WB_alu_valid),
    .WB_alu_addr     (WB_alu_addr),
    .WB_alu_data     (WB_alu_data),
    .WB_ready        (WB_ready),
    .REG_write_1     (REG_write_1),
    .REG_address_wr  (REG_address_wr),
    .REG_data_wb_in1 (REG_data_wb_in1),
    .WB_query_addr1  (WB_query_addr1),
    .WB_query_addr2  (WB_query_addr2),
    .WB_pending1     (WB_pending1),
    .WB_pending2     (WB_pending2),
    .WB_fwd_data1    (WB_fwd_data1),
    .WB_fwd_data2    (WB_fwd_data2),
    .WB_count        (WB_count),
    .WB_overflow     (WB_overflow)
  );

  always #5 clk = ~clk;

  // Behavioural model: a plain FIFO of pending writes, the last write-port value, and the sticky flag.
  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } ment_t;

  ment_t mq[$];
  logic  m_out_vld;
  ment_t m_out;
  logic  m_ovf;

  int checks = 0;
  int failures = 0;
  int dropped_seen = 0;

  // Addresses 62/63 are only used by requests that must be dropped.
  always @(negedge clk) begin
    if (REG_write_1 === 1'b1 && REG_address_wr >= 6'd62) dropped_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_fwd(input logic [5:0] qa, output logic p, output logic [31:0] d);
    p = 1'b0;
    d = '0;
    if (qa != 6'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].a == qa) begin
          p = 1'b1;
          d = mq[i].d;
          break;
        end
      end
      if (!p && m_out_vld && m_out.a == qa) begin
        p = 1'b1;
        d = m_out.d;
      end
    end
  endfunction

  task automatic model_reset();
    mq.delete();
    m_out_vld = 1'b0;
    m_out     = '{a: 6'd0, d: 32'd0};
    m_ovf     = 1'b0;
  endtask

  task automatic check_all();
    logic        p;
    logic [31:0] d;
    chk("ready", 32'(WB_ready), 32'(((DEPTH - mq.size()) >= 2) ? 1 : 0));
    chk("count", 32'(WB_count), 32'(mq.size()));
    chk("reg_write", 32'(REG_write_1), 32'(m_out_vld));
    if (m_out_vld) begin
      chk("reg_addr", 32'(REG_address_wr), 32'(m_out.a));
      chk("reg_data", REG_data_wb_in1, m_out.d);
    end
    chk("overflow", 32'(WB_overflow), 32'(m_ovf));
    model_fwd(WB_query_addr1, p, d);
    chk("pending1", 32'(WB_pending1), 32'(p));
    chk("fwd1", WB_fwd_data1, d);
    model_fwd(WB_query_addr2, p, d);
    chk("pending2", 32'(WB_pending2), 32'(p));
    chk("fwd2", WB_fwd_data2, d);
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit rdy;
    rdy = (DEPTH - mq.size()) >= 2;
    if (mq.size() > 0) begin
      m_out     = mq.pop_front();
      m_out_vld = 1'b1;
    end else begin
      m_out_vld = 1'b0;
    end
    if (WB_mem_valid && WB_mem_addr != 6'd0) begin
      if (rdy) mq.push_back('{a: WB_mem_addr, d: WB_mem_data});
      else     m_ovf = 1'b1;
    end
    if (WB_alu_valid && WB_alu_addr != 6'd0) begin
      if (rdy) mq.push_back('{a: WB_alu_addr, d: WB_alu_data});
      else     m_ovf = 1'b1;
    end
  endtask

  // One clock: drive at the falling edge, check current state, step the model, cross the rising edge.
  task automatic cycle(input logic mv, input logic [5:0] ma, input logic [31:0] md,
                       input logic av, input logic [5:0] aa, input logic [31:0] ad,
                       input logic [5:0] q1, input logic [5:0] q2);
    WB_mem_valid   = mv;
    WB_mem_addr    = ma;
    WB_mem_data    = md;
    WB_alu_valid   = av;
    WB_alu_addr    = aa;
    WB_alu_data    = ad;
    WB_query_addr1 = q1;
    WB_query_addr2 = q2;
    #1;
    check_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic [5:0] q1, input logic [5:0] q2);
    cycle(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, q1, q2);
  endtask

  initial begin
    rst = 1'b1;
    WB_mem_valid = 1'b0; WB_mem_addr = '0; WB_mem_data = '0;
    WB_alu_valid = 1'b0; WB_alu_addr = '0; WB_alu_data = '0;
    WB_query_addr1 = '0; WB_query_addr2 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(WB_count), 32'd0);
    chk("rst_ready", 32'(WB_ready), 32'd1);
    chk("rst_write", 32'(REG_write_1), 32'd0);
    chk("rst_addr", 32'(REG_address_wr), 32'd0);
    chk("rst_data", REG_data_wb_in1, 32'd0);
    chk("rst_ovf", 32'(WB_overflow), 32'd0);
    rst = 1'b0;

    // Single ALU write
    cycle(1'b0, 6'd0, 32'd0, 1'b1, 6'd5, 32'h0000_00AA, 6'd5, 6'd0);
    idle(6'd5, 6'd0);
    chk("single_write", 32'(REG_write_1), 32'd1);
    chk("single_addr", 32'(REG_address_wr), 32'd5);
    chk("single_data", REG_data_wb_in1, 32'h0000_00AA);
    idle(6'd5, 6'd0);
    chk("single_done", 32'(REG_write_1), 32'd0);

    // Dual same-address writes: mem first, ALU value forwarded
    cycle(1'b1, 6'd3, 32'h11, 1'b1, 6'd3, 32'h22, 6'd3, 6'd3);
    chk("dual_fwd_q", WB_fwd_data1, 32'h22);
    idle(6'd3, 6'd0);
    chk("dual_first", REG_data_wb_in1, 32'h11);
    chk("dual_fwd_mid", WB_fwd_data1, 32'h22);
    idle(6'd3, 6'd0);
    chk("dual_second", REG_data_wb_in1, 32'h22);
    idle(6'd3, 6'd0);
    idle(6'd3, 6'd0);
    chk("dual_pend_clear", 32'(WB_pending1), 32'd0);

    // Register 0 request
    cycle(1'b0, 6'd0, 32'd0, 1'b1, 6'd0, 32'h77, 6'd0, 6'd0);
    chk("zero_count", 32'(WB_count), 32'd0);
    chk("zero_ovf", 32'(WB_overflow), 32'd0);
    chk("zero_write", 32'(REG_write_1), 32'd0);
    idle(6'd0, 6'd0);

    // Fill until not ready, then a dropped request
    cycle(1'b1, 6'd1, 32'h101, 1'b1, 6'd2, 32'h102, 6'd1, 6'd2);
    cycle(1'b1, 6'd3, 32'h103, 1'b1, 6'd4, 32'h104, 6'd3, 6'd4);
    chk("fill_count3", 32'(WB_count), 32'd3);
    chk("fill_notready", 32'(WB_ready), 32'd0);
    cycle(1'b1, 6'd62, 32'hDEAD, 1'b1, 6'd63, 32'hBEEF, 6'd62, 6'd63);
    chk("fill_ovf", 32'(WB_overflow), 32'd1);
    repeat (4) idle(6'd4, 6'd62);
    chk("fill_drained", 32'(WB_count), 32'd0);

    // Ten sequential writes wrap the pointers
    for (int i = 1; i <= 10; i++)
      cycle(1'b0, 6'd0, 32'd0, 1'b1, 6'(i), 32'h1000 + 32'(i), 6'(i), 6'(i - 1));
    repeat (3) idle(6'd10, 6'd9);
    chk("wrap_count", 32'(WB_count), 32'd0);

    // Asynchronous reset with entries queued and a write in flight
    cycle(1'b1, 6'd7, 32'h207, 1'b1, 6'd8, 32'h208, 6'd7, 6'd8);
    cycle(1'b1, 6'd9, 32'h209, 1'b1, 6'd10, 32'h20A, 6'd9, 6'd10);
    chk("mid_count3", 32'(WB_count), 32'd3);
    WB_mem_valid = 1'b0;
    WB_alu_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_write", 32'(REG_write_1), 32'd0);
    chk("mid_rst_count", 32'(WB_count), 32'd0);
    chk("mid_rst_ready", 32'(WB_ready), 32'd1);
    chk("mid_rst_ovf", 32'(WB_overflow), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) idle(6'd9, 6'd10);
    chk("mid_no_write", 32'(REG_write_1), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic mv, av;
      mv = ($urandom_range(0, 1) == 1);
      av = ($urandom_range(0, 1) == 1);
      cycle(mv, 6'($urandom_range(0, 7)), $urandom(),
            av, 6'($urandom_range(0, 7)), $urandom(),
            6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)));
    end
    repeat (6) idle(6'd1, 6'd2);
    check_all();
    chk("dropped_never_written", 32'(dropped_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_wb_queue.md
REG_WB_QUEUE -- requirements
Module: reg_wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of pending-writeback entries (power of two, >= 2).
REQ-002 SHALL have parameter AW, default 6, meaning the register address width.
REQ-003 SHALL have parameter DW, default 32, meaning the register data width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports WB_mem_valid/WB_mem_addr/WB_mem_data  input  1/AW/DW  load-result writeback request.
REQ-007 SHALL have ports WB_alu_valid/WB_alu_addr/WB_alu_data  input  1/AW/DW  ALU-result writeback request.
REQ-008 SHALL have port WB_ready  output  1  high when at least 2 entries are free.
REQ-009 SHALL have ports REG_write_1/REG_address_wr/REG_data_wb_in1  output  1/AW/DW  register-file write port, driven from registers.
REQ-010 SHALL have ports WB_query_addr1/WB_query_addr2  input  AW each  decode-stage source addresses.
REQ-011 SHALL have ports WB_pending1/WB_pending2  output  1 each  query address has an outstanding write.
REQ-012 SHALL have ports WB_fwd_data1/WB_fwd_data2  output  DW each  youngest outstanding data for that query.
REQ-013 SHALL have port WB_count  output  $clog2(DEPTH)+1  current number of queued entries.
REQ-014 SHALL have port WB_overflow  output  1  sticky: a request was dropped.

Function
REQ-015 SHALL hold entries in FIFO order in a circular buffer, with head/tail pointers wrapping modulo DEPTH.
REQ-016 SHALL enqueue a request only when valid=1, addr!=0 and WB_ready=1; an addr 0 request is silently discarded and does not count as overflow.
REQ-017 SHALL, when both sources enqueue in one cycle, place the mem entry first, then the alu entry (mem is older).
REQ-018 SHALL, when a valid non-zero request arrives with WB_ready=0, drop it and set WB_overflow=1 until reset.
REQ-019 SHALL pop the head every cycle the queue is non-empty and load it into the output registers, giving REG_write_1=1 on the following cycle; REG_write_1=0 otherwise.
REQ-020 SHALL give a minimum latency of 1 cycle: a request accepted at edge N into an empty queue appears on the write port after edge N+1.
REQ-021 SHALL allow enqueue and pop in the same cycle; WB_count updates by (+enqueued -popped), ranging 0..DEPTH.
REQ-022 SHALL compute WB_ready = (DEPTH - WB_count) >= 2 from registered state only (no dependence on valid inputs).
REQ-023 SHALL compute WB_pendingN combinationally as a match against all queued entries plus the output register while REG_write_1=1; a query of address 0 gives pending=0 and fwd=0.
REQ-024 SHALL return in WB_fwd_dataN the data of the youngest matching entry (queue tail side beats the output register); when there is no match it returns 0.
REQ-025 SHALL NOT reorder or merge same-address entries; each is written in order.

Reset
REQ-026 SHALL, on rst=1 (asynchronous), clear head, tail and count to 0, REG_write_1 to 0, REG_address_wr and REG_data_wb_in1 to 0, and WB_overflow to 0; WB_ready is then 1.
REQ-027 SHALL, on reset mid-operation, discard all queued and in-flight entries with no write-port pulse; entry storage need not be cleared.

Structure
REQ-028 SHALL take AW, DW and DEPTH defaults, and the entry typedef {addr, data}, from a shared processor package.
REQ-029 SHALL implement the youngest-match search as sub-module wb_match, instantiated once per query port.

Verification
REQ-030 Single: reset, then alu (addr 5, 0x0000_00AA) -> next cycle REG_write_1=1, addr 5, data 0xAA, then REG_write_1=0.
REQ-031 Dual: mem (3, 0x11) and alu (3, 0x22) in the same cycle -> writes of 0x11 then 0x22 on consecutive cycles; query 3 returns fwd 0x22 until the second write completes.
REQ-032 Zero register: alu addr 0 -> no write, WB_count unchanged, WB_overflow=0.
REQ-033 Fill: hold the queue full via dual requests with DEPTH=4 -> WB_ready=0 at count 3 and 4; a request then sets WB_overflow=1 and is never written.
REQ-034 Wrap: 10 sequential single requests with addresses 1..10 -> 10 in-order writes, pointers wrap, WB_count returns to 0.
REQ-035 Reset mid-stream: assert rst with 3 entries queued -> REG_write_1=0 immediately, count 0, no further writes after release.
